// File: rtl/cavlc_rbsp_window.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_rbsp_window
// Brief    : RBSP bit-window feeder for cavlc_top. Buffers input words MSB-first
//            and presents a WIN_W-bit look-ahead window that advances by a
//            variable consume length each cycle.
//            Optional macro CAVLC_RBSP_BITCNT_EN adds the bit_pos output.
// Revision : 1.0 - initial release
// ============================================================================
module cavlc_rbsp_window #(
    parameter int IN_W  = 32,
    parameter int WIN_W = 16,
    parameter int BUF_W = 64,
    parameter int LEN_W = 5,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             flush,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             consume,
    input  logic [LEN_W-1:0] consume_len,
    output logic [WIN_W-1:0] win,
    output logic             win_valid,
    output logic [CNT_W-1:0] fill,
`ifdef CAVLC_RBSP_BITCNT_EN
    output logic [31:0]      bit_pos,
`endif
    output logic             err
);

    localparam logic [CNT_W:0]   C_ROOM  = (CNT_W+1)'(BUF_W - IN_W);
    localparam logic [LEN_W-1:0] C_WIN_L = LEN_W'(WIN_W);
    localparam logic [CNT_W-1:0] C_WIN_C = CNT_W'(WIN_W);
    localparam logic [CNT_W-1:0] C_IN_C  = CNT_W'(IN_W);

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic [CNT_W-1:0] w_len_ext;
    logic             w_illegal;
    logic             w_legal;
    logic             w_push;
    logic [CNT_W-1:0] w_l;
    logic [CNT_W-1:0] w_rem;
    logic [BUF_W-1:0] w_in_ext;
    logic [BUF_W-1:0] w_buf_next;
    logic [CNT_W-1:0] w_cnt_next;

    // in_ready depends only on registered fill so there is no path from consume
    assign in_ready  = ena && !flush && ({1'b0, r_cnt} <= C_ROOM);

    assign w_len_ext = CNT_W'(consume_len);
    assign w_illegal = ena && consume && ((consume_len > C_WIN_L) || (w_len_ext > r_cnt));
    assign w_legal   = ena && consume && !w_illegal;
    assign w_push    = in_valid && in_ready;
    assign w_l       = w_legal ? w_len_ext : '0;
    assign w_rem     = r_cnt - w_l;

    // Shift first, then drop the new word directly below the surviving bits
    assign w_in_ext   = {in_data, {(BUF_W-IN_W){1'b0}}};
    assign w_buf_next = (r_buf << w_l) | (w_push ? (w_in_ext >> w_rem) : '0);
    assign w_cnt_next = w_rem + (w_push ? C_IN_C : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (ena) begin
            if (flush) begin
                r_buf <= '0;
                r_cnt <= '0;
                r_err <= 1'b0;
            end else begin
                r_buf <= w_buf_next;
                r_cnt <= w_cnt_next;
                if (w_illegal)
                    r_err <= 1'b1;
            end
        end
    end

`ifdef CAVLC_RBSP_BITCNT_EN
    logic [31:0] r_bit_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_bit_pos <= '0;
        else if (ena) begin
            if (flush)
                r_bit_pos <= '0;
            else
                r_bit_pos <= r_bit_pos + 32'(w_l);
        end
    end

    assign bit_pos = r_bit_pos;
`endif

    assign win       = r_buf[BUF_W-1 -: WIN_W];
    assign win_valid = (r_cnt >= C_WIN_C);
    assign fill      = r_cnt;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_rbsp_window.sv
`default_nettype none
// ============================================================================
// Module   : tb_cavlc_rbsp_window
// Brief    : Self-checking bench for cavlc_rbsp_window (scoreboard of expected
//            window state per driven cycle, plus a bit-queue reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cavlc_rbsp_window;

    typedef struct packed {
        logic        e;
        logic        f;
        logic        v;
        logic [31:0] d;
        logic        c;
        logic [4:0]  l;
        logic [15:0] win;
        logic [6:0]  fill;
        logic        wv;
        logic        rdy;
        logic        err;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        consume;
    logic [4:0]  consume_len;
    logic [15:0] win;
    logic        win_valid;
    logic [6:0]  fill;
    logic        err;
`ifdef CAVLC_RBSP_BITCNT_EN
    logic [31:0] bit_pos;
`endif

    int checks = 0;
    int errors = 0;
    step_t sb[$];

    cavlc_rbsp_window #(
        .IN_W(32), .WIN_W(16), .BUF_W(64), .LEN_W(5), .CNT_W(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .consume(consume), .consume_len(consume_len),
        .win(win), .win_valid(win_valid), .fill(fill),
`ifdef CAVLC_RBSP_BITCNT_EN
        .bit_pos(bit_pos),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(input logic e, input logic f, input logic v,
                                 input logic [31:0] d, input logic c, input logic [4:0] l,
                                 input logic [15:0] w, input logic [6:0] fl,
                                 input logic wv, input logic rdy, input logic er);
        step_t s;
        s = '{e: e, f: f, v: v, d: d, c: c, l: l, win: w, fill: fl, wv: wv, rdy: rdy, err: er};
        return s;
    endfunction

    task automatic drive(input step_t s);
        ena = s.e; flush = s.f; in_valid = s.v; in_data = s.d;
        consume = s.c; consume_len = s.l;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ena = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; consume = 1'b0; consume_len = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({win, fill, win_valid, in_ready, err} !== 27'd0) begin
            errors++;
            $display("FAIL reset: got win=%h fill=%0d wv=%b rdy=%b err=%b, expected all zero",
                     win, fill, win_valid, in_ready, err);
        end
        rst_n = 1'b1; ena = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({fill, in_ready, win_valid} !== {7'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle: got fill=%0d rdy=%b wv=%b, expected fill=0 rdy=1 wv=0",
                     fill, in_ready, win_valid);
        end
    endtask

    task automatic test_push_consume;
        step_t s[$];
        step_t x;
        s.push_back(mk(1, 0, 1, 32'hF0F0_1234, 0, 5'd0,  16'hF0F0, 7'd32, 1, 1, 0));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd4,  16'h0F01, 7'd28, 1, 1, 0));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd12, 16'h1234, 7'd16, 1, 1, 0));
        foreach (s[i]) begin
            sb.push_back(s[i]);
            drive(s[i]);
            x = sb.pop_front();
            checks++;
            if ({win, fill, win_valid, in_ready, err} !== {x.win, x.fill, x.wv, x.rdy, x.err}) begin
                errors++;
                $display("FAIL push_consume[%0d]: got win=%h fill=%0d wv=%b rdy=%b err=%b, expected win=%h fill=%0d wv=%b rdy=%b err=%b",
                         i, win, fill, win_valid, in_ready, err, x.win, x.fill, x.wv, x.rdy, x.err);
            end
        end
    endtask

    task automatic test_back_to_back;
        step_t s[$];
        step_t x;
        s.push_back(mk(1, 1, 0, 32'h0,         0, 5'd0,  16'h0000, 7'd0,  0, 0, 0));
        s.push_back(mk(1, 0, 1, 32'hF0F0_1234, 0, 5'd0,  16'hF0F0, 7'd32, 1, 1, 0));
        s.push_back(mk(1, 0, 1, 32'hABCD_0000, 1, 5'd16, 16'h1234, 7'd48, 1, 0, 0));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd16, 16'hABCD, 7'd32, 1, 1, 0));
        foreach (s[i]) begin
            sb.push_back(s[i]);
            drive(s[i]);
            x = sb.pop_front();
            checks++;
            if ({win, fill, win_valid, in_ready, err} !== {x.win, x.fill, x.wv, x.rdy, x.err}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got win=%h fill=%0d wv=%b rdy=%b err=%b, expected win=%h fill=%0d wv=%b rdy=%b err=%b",
                         i, win, fill, win_valid, in_ready, err, x.win, x.fill, x.wv, x.rdy, x.err);
            end
        end
    endtask

    task automatic test_full;
        step_t s[$];
        step_t x;
        s.push_back(mk(1, 1, 0, 32'h0,         0, 5'd0,  16'h0000, 7'd0,  0, 0, 0));
        s.push_back(mk(1, 0, 1, 32'h1111_2222, 0, 5'd0,  16'h1111, 7'd32, 1, 1, 0));
        s.push_back(mk(1, 0, 1, 32'h3333_4444, 0, 5'd0,  16'h1111, 7'd64, 1, 0, 0));
        s.push_back(mk(1, 0, 1, 32'h5555_6666, 0, 5'd0,  16'h1111, 7'd64, 1, 0, 0));
        s.push_back(mk(1, 0, 1, 32'h5555_6666, 1, 5'd16, 16'h2222, 7'd48, 1, 0, 0));
        s.push_back(mk(1, 0, 1, 32'h5555_6666, 1, 5'd16, 16'h3333, 7'd32, 1, 1, 0));
        s.push_back(mk(1, 0, 1, 32'h5555_6666, 0, 5'd0,  16'h3333, 7'd64, 1, 0, 0));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd16, 16'h4444, 7'd48, 1, 0, 0));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd16, 16'h5555, 7'd32, 1, 1, 0));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd16, 16'h6666, 7'd16, 1, 1, 0));
        foreach (s[i]) begin
            sb.push_back(s[i]);
            drive(s[i]);
            x = sb.pop_front();
            checks++;
            if ({win, fill, win_valid, in_ready, err} !== {x.win, x.fill, x.wv, x.rdy, x.err}) begin
                errors++;
                $display("FAIL full[%0d]: got win=%h fill=%0d wv=%b rdy=%b err=%b, expected win=%h fill=%0d wv=%b rdy=%b err=%b",
                         i, win, fill, win_valid, in_ready, err, x.win, x.fill, x.wv, x.rdy, x.err);
            end
        end
    endtask

    task automatic test_illegal_consume;
        step_t s[$];
        step_t x;
        s.push_back(mk(1, 1, 0, 32'h0,         0, 5'd0,  16'h0000, 7'd0,  0, 0, 0));
        s.push_back(mk(1, 0, 1, 32'hF0F0_1234, 0, 5'd0,  16'hF0F0, 7'd32, 1, 1, 0));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd16, 16'h1234, 7'd16, 1, 1, 0));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd17, 16'h1234, 7'd16, 1, 1, 1));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd12, 16'h4000, 7'd4,  0, 1, 1));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd5,  16'h4000, 7'd4,  0, 1, 1));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd4,  16'h0000, 7'd0,  0, 1, 1));
        s.push_back(mk(1, 0, 1, 32'hAAAA_5555, 1, 5'd1,  16'hAAAA, 7'd32, 1, 1, 1));
        foreach (s[i]) begin
            sb.push_back(s[i]);
            drive(s[i]);
            x = sb.pop_front();
            checks++;
            if ({win, fill, win_valid, in_ready, err} !== {x.win, x.fill, x.wv, x.rdy, x.err}) begin
                errors++;
                $display("FAIL illegal[%0d]: got win=%h fill=%0d wv=%b rdy=%b err=%b, expected win=%h fill=%0d wv=%b rdy=%b err=%b",
                         i, win, fill, win_valid, in_ready, err, x.win, x.fill, x.wv, x.rdy, x.err);
            end
        end
    endtask

    task automatic test_flush;
        step_t s[$];
        step_t x;
        s.push_back(mk(1, 1, 1, 32'h1234_5678, 1, 5'd4, 16'h0000, 7'd0, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 32'h0,         0, 5'd0, 16'h0000, 7'd0, 0, 1, 0));
        foreach (s[i]) begin
            sb.push_back(s[i]);
            drive(s[i]);
            x = sb.pop_front();
            checks++;
            if ({win, fill, win_valid, in_ready, err} !== {x.win, x.fill, x.wv, x.rdy, x.err}) begin
                errors++;
                $display("FAIL flush[%0d]: got win=%h fill=%0d wv=%b rdy=%b err=%b, expected win=%h fill=%0d wv=%b rdy=%b err=%b",
                         i, win, fill, win_valid, in_ready, err, x.win, x.fill, x.wv, x.rdy, x.err);
            end
`ifdef CAVLC_RBSP_BITCNT_EN
            checks++;
            if (bit_pos !== 32'd0) begin
                errors++;
                $display("FAIL flush_bit_pos[%0d]: got %0d, expected 0", i, bit_pos);
            end
`endif
        end
    endtask

    task automatic test_ena_hold;
        step_t s[$];
        step_t x;
        s.push_back(mk(1, 0, 1, 32'hF0F0_1234, 0, 5'd0,  16'hF0F0, 7'd32, 1, 1, 0));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd4,  16'h0F01, 7'd28, 1, 1, 0));
        s.push_back(mk(0, 0, 1, 32'h9999_9999, 1, 5'd4,  16'h0F01, 7'd28, 1, 0, 0));
        s.push_back(mk(0, 0, 1, 32'h9999_9999, 1, 5'd20, 16'h0F01, 7'd28, 1, 0, 0));
        s.push_back(mk(0, 1, 1, 32'h9999_9999, 1, 5'd4,  16'h0F01, 7'd28, 1, 0, 0));
        s.push_back(mk(1, 0, 0, 32'h0,         1, 5'd12, 16'h1234, 7'd16, 1, 1, 0));
        foreach (s[i]) begin
            sb.push_back(s[i]);
            drive(s[i]);
            x = sb.pop_front();
            checks++;
            if ({win, fill, win_valid, in_ready, err} !== {x.win, x.fill, x.wv, x.rdy, x.err}) begin
                errors++;
                $display("FAIL ena_hold[%0d]: got win=%h fill=%0d wv=%b rdy=%b err=%b, expected win=%h fill=%0d wv=%b rdy=%b err=%b",
                         i, win, fill, win_valid, in_ready, err, x.win, x.fill, x.wv, x.rdy, x.err);
            end
        end
    endtask

    // Reference model keeps the stream as a plain queue of bits
    task automatic test_random_stream;
        bit          mq[$];
        logic        merr;
        logic [31:0] mpos;
        step_t       s;
        step_t       x;
        logic [31:0] pos_q[$];
        logic [31:0] epos;
        bit          acc;
        mq.delete(); merr = 1'b0; mpos = '0;
        drive(mk(1, 1, 0, 32'h0, 0, 5'd0, 16'h0, 7'd0, 0, 0, 0));
        for (int n = 0; n < 400; n++) begin
            s.e = ($urandom_range(0, 9) != 0);
            s.f = ($urandom_range(0, 39) == 0);
            s.v = ($urandom_range(0, 9) < 6);
            s.d = $urandom;
            s.c = ($urandom_range(0, 9) < 7);
            s.l = 5'($urandom_range(0, 17));
            if (s.e) begin
                if (s.f) begin
                    mq.delete(); merr = 1'b0; mpos = '0;
                end else begin
                    acc = s.v && (mq.size() + 32 <= 64);
                    if (s.c) begin
                        if (s.l > 16 || int'(s.l) > mq.size())
                            merr = 1'b1;
                        else begin
                            for (int k = 0; k < int'(s.l); k++) void'(mq.pop_front());
                            mpos = mpos + 32'(s.l);
                        end
                    end
                    if (acc)
                        for (int k = 31; k >= 0; k--) mq.push_back(s.d[k]);
                end
            end
            for (int k = 0; k < 16; k++)
                s.win[15-k] = (k < mq.size()) ? mq[k] : 1'b0;
            s.fill = 7'(mq.size());
            s.wv   = (mq.size() >= 16);
            s.rdy  = s.e && !s.f && (mq.size() <= 32);
            s.err  = merr;
            sb.push_back(s);
            pos_q.push_back(mpos);
            drive(s);
            x = sb.pop_front();
            epos = pos_q.pop_front();
            checks++;
            if ({win, fill, win_valid, in_ready, err} !== {x.win, x.fill, x.wv, x.rdy, x.err}) begin
                errors++;
                $display("FAIL random[%0d]: got win=%h fill=%0d wv=%b rdy=%b err=%b, expected win=%h fill=%0d wv=%b rdy=%b err=%b",
                         n, win, fill, win_valid, in_ready, err, x.win, x.fill, x.wv, x.rdy, x.err);
            end
`ifdef CAVLC_RBSP_BITCNT_EN
            checks++;
            if (bit_pos !== epos) begin
                errors++;
                $display("FAIL random_bit_pos[%0d]: got %0d, expected %0d", n, bit_pos, epos);
            end
`endif
        end
    endtask

    task automatic test_async_reset;
        drive(mk(1, 1, 0, 32'h0, 0, 5'd0, 16'h0, 7'd0, 0, 0, 0));
        drive(mk(1, 0, 1, 32'hDEAD_BEEF, 1, 5'd20, 16'h0, 7'd0, 0, 0, 0));
        in_valid = 1'b0; consume = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({win, fill, win_valid, err} !== 25'd0) begin
            errors++;
            $display("FAIL async_reset: got win=%h fill=%0d wv=%b err=%b, expected all zero",
                     win, fill, win_valid, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (fill !== 7'd0) begin
            errors++;
            $display("FAIL async_reset_release: got fill=%0d, expected 0", fill);
        end
    endtask

    initial begin
        test_reset();
        test_push_consume();
        test_back_to_back();
        test_full();
        test_illegal_consume();
        test_flush();
        test_ena_hold();
        test_random_stream();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
